// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM states and the HALT opcode field.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam int unsigned OPCODE_W = 4;
  localparam logic [OPCODE_W-1:0] OP_HALT = 4'hF;

  // Opcode occupies the top OPCODE_W bits of the instruction word.
  function automatic logic is_halt(input logic [OPCODE_W-1:0] opcode);
    return opcode == OP_HALT;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter with load / increment / hold; async reset to RESET_PC.
module pc_reg #(
  parameter int unsigned          WIDTH    = 16,
  parameter logic [WIDTH-1:0]     RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             inc,
  output logic [WIDTH-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_value;
    end else if (inc) begin
      pc <= pc + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, IF/ID register, HALT detection.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned      WIDTH            = 16,
  parameter int unsigned      INSTRUCTIONWIDTH = 24,
  parameter logic [WIDTH-1:0] RESET_PC         = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        stall,
  input  logic                        flush,
  input  logic                        branch_taken,
  input  logic [WIDTH-1:0]            branch_target,
  output logic [WIDTH-1:0]            imem_addr,
  input  logic [INSTRUCTIONWIDTH-1:0] imem_rdata,
  output logic [INSTRUCTIONWIDTH-1:0] if_id_instr,
  output logic [WIDTH-1:0]            if_id_pc,
  output logic [WIDTH-1:0]            if_id_pc_next,
  output logic                        if_id_valid,
  output logic                        halted,
  output logic [WIDTH-1:0]            fetch_count
);

  fetch_state_e     state, state_nx;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus1;
  logic             pc_load;
  logic             pc_inc;
  logic             ifid_load;
  logic             valid_clr;
  logic             halt_op;

  pc_reg #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (pc_load),
    .load_value (branch_target),
    .inc        (pc_inc),
    .pc         (pc)
  );

  assign imem_addr = pc;
  assign pc_plus1  = pc + WIDTH'(1);
  assign halt_op   = is_halt(imem_rdata[INSTRUCTIONWIDTH-1 -: OPCODE_W]);
  assign halted    = (state == ST_HALT);

  // RUN priority: branch > flush > stall > normal fetch. In HALT only a
  // branch is honoured; stall merely delays dropping the HALT word's valid.
  always_comb begin
    state_nx  = state;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    ifid_load = 1'b0;
    valid_clr = 1'b0;
    unique case (state)
      ST_BOOT: begin
        valid_clr = 1'b1;
        state_nx  = ST_RUN;
      end
      ST_RUN: begin
        if (branch_taken) begin
          pc_load   = 1'b1;
          valid_clr = 1'b1;
        end else if (flush) begin
          pc_inc    = 1'b1;
          valid_clr = 1'b1;
        end else if (!stall) begin
          ifid_load = 1'b1;
          if (halt_op) begin
            state_nx = ST_HALT;
          end else begin
            pc_inc = 1'b1;
          end
        end
      end
      ST_HALT: begin
        if (branch_taken) begin
          pc_load   = 1'b1;
          valid_clr = 1'b1;
          state_nx  = ST_RUN;
        end else if (!stall) begin
          valid_clr = 1'b1;
        end
      end
      default: state_nx = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_BOOT;
      if_id_instr   <= '0;
      if_id_pc      <= '0;
      if_id_pc_next <= '0;
      if_id_valid   <= 1'b0;
      fetch_count   <= '0;
    end else begin
      state <= state_nx;
      if (ifid_load) begin
        if_id_instr   <= imem_rdata;
        if_id_pc      <= pc;
        if_id_pc_next <= pc_plus1;
        if_id_valid   <= 1'b1;
        fetch_count   <= fetch_count + WIDTH'(1);
      end else if (valid_clr) begin
        if_id_valid <= 1'b0;
      end
    end
  end

endmodule
